// File: rtl/key_click_decoder.sv
// Classifies key gestures as single click, double click or long press; one registered pulse per gesture.
// Pulse appears the cycle after its deciding condition; no backpressure, inputs are sampled every cycle.
module key_click_decoder #(
  parameter logic [19:0] REL_MAX  = 20'd999_999,
  parameter logic [25:0] GAP_MAX  = 26'd14_999_999,
  parameter logic [25:0] LONG_MAX = 26'd49_999_999
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  input  logic press_flag,
  output logic single_click,
  output logic double_click,
  output logic long_press,
  output logic busy
);

  typedef enum logic [2:0] {IDLE, PRESS1, HELD, WAIT_GAP, PRESS2} state_t;

  state_t      state, state_nxt;
  logic        key_meta, key_s;
  logic [19:0] rel_cnt;
  logic        rel_evt;
  logic [25:0] tmr;
  logic        single_nxt, double_nxt, long_nxt;

  // Synchronizer resets to the released level so no false press follows reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_meta <= 1'b1;
      key_s    <= 1'b1;
    end else begin
      key_meta <= key_in;
      key_s    <= key_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rel_cnt <= '0;
    else if (!key_s)
      rel_cnt <= '0;
    else if (rel_cnt != REL_MAX)
      rel_cnt <= rel_cnt + 20'd1;
  end

  // Fires once per release: the count passes REL_MAX-1 only once before saturating.
  assign rel_evt = key_s && (rel_cnt == REL_MAX - 20'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      tmr <= '0;
    else if (state_nxt != state)
      tmr <= '0;
    else if (!(&tmr))
      tmr <= tmr + 26'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      single_click <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
    end else begin
      state        <= state_nxt;
      single_click <= single_nxt;
      double_click <= double_nxt;
      long_press   <= long_nxt;
    end
  end

  // Priority: long expiry beats release in PRESS1, second press beats gap expiry in WAIT_GAP.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (press_flag) state_nxt = PRESS1;
      PRESS1:   if (tmr == LONG_MAX - 26'd1) state_nxt = HELD;
                else if (rel_evt) state_nxt = WAIT_GAP;
      HELD:     if (rel_evt) state_nxt = IDLE;
      WAIT_GAP: if (press_flag) state_nxt = PRESS2;
                else if (tmr == GAP_MAX - 26'd1) state_nxt = IDLE;
      PRESS2:   if (rel_evt) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    single_nxt = 1'b0;
    double_nxt = 1'b0;
    long_nxt   = 1'b0;
    case (state)
      PRESS1:   long_nxt   = (tmr == LONG_MAX - 26'd1);
      WAIT_GAP: single_nxt = !press_flag && (tmr == GAP_MAX - 26'd1);
      PRESS2:   double_nxt = rel_evt;
      default:  ;
    endcase
  end

  assign busy = (state != IDLE);

endmodule
